// File: rtl/capture_pkg.sv
// Shared constants and state encoding for the raw-sample capture path.
// The filter/beamform controller imports the same constants for its read addressing.
package capture_pkg;

    localparam int DATA_W   = 16;
    localparam int CHANNELS = 8;
    localparam int SAMPLES  = 2048;
    localparam int ADDR_W   = 14;

    localparam int CHAN_W = $clog2(CHANNELS);
    localparam int IDX_W  = $clog2(SAMPLES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        FULL    = 2'd2
    } state_t;

endpackage

// File: rtl/capture_addr_gen.sv
// Channel/sample counters for the raw RAM write address.
// Decodes end of channel, the final slot of the frame, and s_last misplacement.
module capture_addr_gen
    import capture_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,      // restart at channel 0, sample 0
    input  logic              step,       // a sample is accepted this cycle
    input  logic              last,       // s_last of the accepted sample
    output logic [ADDR_W-1:0] addr,       // {chan, idx} of the sample at the stream head
    output logic              chan_end,   // the accepted sample closes its channel block
    output logic              frame_end,  // counters sit on the final slot of the frame
    output logic              err         // accepted sample has s_last in the wrong place
);

    localparam logic [CHAN_W-1:0] LAST_CHAN = CHAN_W'(CHANNELS - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(SAMPLES - 1);

    logic [CHAN_W-1:0] r_chan;
    logic [IDX_W-1:0]  r_idx;
    logic              w_idx_last;

    assign w_idx_last = (r_idx == LAST_IDX);
    assign addr       = {r_chan, r_idx};

    // A block closes on s_last or on its last index, whichever comes first.
    assign chan_end  = step & (last | w_idx_last);
    // Frame completion depends on position only; s_last alone never ends a frame.
    assign frame_end = w_idx_last & (r_chan == LAST_CHAN);
    // Short block (s_last early) or long block (no s_last on the last index).
    assign err       = step & (last ^ w_idx_last);

    // Counter update: idx advances per sample, chan advances (and wraps) per block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_chan <= '0;
            r_idx  <= '0;
        end else if (clear) begin
            r_chan <= '0;
            r_idx  <= '0;
        end else if (chan_end) begin
            r_chan <= r_chan + 1'b1;
            r_idx  <= '0;
        end else if (step) begin
            r_idx  <= r_idx + 1'b1;
        end
    end

endmodule

// File: rtl/raw_capture.sv
// Writer side of the raw-sample RAM: stores one channel-major frame, then
// hands the RAM to the controller until it is released.
// The release handshake port is called release_req because "release" is a
// reserved word in SystemVerilog.
module raw_capture
    import capture_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              release_req,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              frame_ready,
    output logic [7:0]        frame_count,
    output logic              err_framing,
    output logic              busy
);

    state_t            r_state;
    state_t            w_state_next;
    logic              w_transfer;
    logic              w_clear;
    logic              w_chan_end;
    logic              w_frame_end;
    logic              w_frame_done;
    logic              w_err;
    logic [ADDR_W-1:0] w_addr;

    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata;
    logic [7:0]        r_frame_count;
    logic              r_err_framing;

    assign s_ready      = (r_state == CAPTURE);
    assign busy         = (r_state == CAPTURE);
    assign w_transfer   = s_valid & s_ready;
    // Last slot accepted: this is the transfer that completes the frame.
    assign w_frame_done = w_chan_end & w_frame_end;

    capture_addr_gen u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .clear     (w_clear),
        .step      (w_transfer),
        .last      (s_last),
        .addr      (w_addr),
        .chan_end  (w_chan_end),
        .frame_end (w_frame_end),
        .err       (w_err)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state; start only acts in IDLE, release only in FULL (release wins there).
    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        frame_ready  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = CAPTURE;
                    w_clear      = 1'b1;
                end
            end
            CAPTURE: begin
                if (w_frame_done) begin
                    w_state_next = FULL;
                end
            end
            FULL: begin
                frame_ready = 1'b1;
                if (release_req) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Registered RAM write port: one cycle after each accepted sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
        end else begin
            r_ram_we <= w_transfer;
            if (w_transfer) begin
                r_ram_addr  <= w_addr;
                r_ram_wdata <= s_data;
            end
        end
    end

    // Frame counter and sticky framing flag (cleared only by an accepted start).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_count <= '0;
            r_err_framing <= 1'b0;
        end else begin
            if (w_transfer && w_frame_done) begin
                r_frame_count <= r_frame_count + 8'd1;
            end
            if (w_clear) begin
                r_err_framing <= 1'b0;
            end else if (w_err) begin
                r_err_framing <= 1'b1;
            end
        end
    end

    assign ram_we      = r_ram_we;
    assign ram_addr    = r_ram_addr;
    assign ram_wdata   = r_ram_wdata;
    assign frame_count = r_frame_count;
    assign err_framing = r_err_framing;

endmodule

// File: tb/tb_raw_capture.sv
// Directed bench for raw_capture: reset mid-stream, clean frame with gaps,
// short block, hold/release and ignored controls, long block.
module tb_raw_capture;
    import capture_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              release_req;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    logic              s_ready;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              frame_ready;
    logic [7:0]        frame_count;
    logic              err_framing;
    logic              busy;

    always #5 clk = ~clk;

    raw_capture dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .release_req (release_req),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .frame_ready (frame_ready),
        .frame_count (frame_count),
        .err_framing (err_framing),
        .busy        (busy)
    );

    // Behavioural raw RAM written from the DUT write port.
    logic [DATA_W-1:0] mem [0:16383];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    int n_checks = 0;
    int n_errors = 0;
    int we_bad   = 0;   // ram_we differs from "transfer in previous cycle"
    int addr_bad = 0;   // written addr/data differs from expected
    int err_bad  = 0;   // err_framing differs from expected after a transfer
    int fr_bad   = 0;   // frame_ready differs from expected after a transfer

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle of stimulus; verifies the write port in the following cycle.
    task automatic cyc(input logic v, input logic [15:0] d, input logic l,
                       input logic st, input logic rl, input logic [13:0] exp_a,
                       output logic xfer);
        s_valid = v; s_data = d; s_last = l; start = st; release_req = rl;
        #1;
        xfer = v && s_ready;
        @(posedge clk);
        #1;
        if (ram_we !== xfer) we_bad++;
        if (xfer && (ram_addr !== exp_a || ram_wdata !== d)) addr_bad++;
        s_valid = 1'b0; s_last = 1'b0; start = 1'b0; release_req = 1'b0;
    endtask

    // Streams n_samp samples with random gaps; short_at (>=0) puts an early s_last
    // on that sample number, and later samples land after the skipped addresses.
    task automatic run_frame(input int n_samp, input int short_at, input logic [15:0] mask);
        int        tries;
        int        skip;
        logic      x;
        logic [13:0] a;
        skip = (short_at >= 0) ? 2047 - (short_at % 2048) : 0;
        for (int n = 0; n < n_samp; n++) begin
            a = 14'((short_at >= 0 && n > short_at) ? n + skip : n);
            tries = 0;
            do begin
                cyc($urandom_range(0, 3) != 0, 16'(a) ^ mask,
                    (a[10:0] == 11'h7FF) || (n == short_at), 1'b0, 1'b0, a, x);
                tries++;
            end while (!x && tries < 64);
            if (!x) begin
                check("stream stall", 32'(x), 32'd1);
                return;
            end
            if (err_framing !== ((short_at >= 0 && n >= short_at) ? 1'b1 : 1'b0)) err_bad++;
            if (frame_ready !== ((n == n_samp - 1) ? 1'b1 : 1'b0)) fr_bad++;
        end
    endtask

    initial begin
        logic x;
        int   bad;
        reset = 1'b1; start = 1'b0; release_req = 1'b0;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst s_ready",     32'(s_ready), 0);
        check("rst ram_we",      32'(ram_we), 0);
        check("rst ram_addr",    32'(ram_addr), 0);
        check("rst ram_wdata",   32'(ram_wdata), 0);
        check("rst frame_ready", 32'(frame_ready), 0);
        check("rst frame_count", 32'(frame_count), 0);
        check("rst err_framing", 32'(err_framing), 0);
        check("rst busy",        32'(busy), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Reset in the middle of a stream.
        cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 14'd0, x);
        check("start s_ready", 32'(s_ready), 1);
        check("start busy",    32'(busy), 1);
        for (int i = 0; i < 100; i++) cyc(1'b1, 16'h1000 + 16'(i), 1'b0, 1'b0, 1'b0, 14'(i), x);
        check("mid addr 99", 32'(ram_addr), 99);
        #2 reset = 1'b1;
        #1;
        check("async rst ram_we",  32'(ram_we), 0);
        check("async rst s_ready", 32'(s_ready), 0);
        check("async rst busy",    32'(busy), 0);
        check("async rst addr",    32'(ram_addr), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        cyc(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0, 14'd0, x);
        check("no start xfer", 32'(x), 0);
        check("no start frame_ready", 32'(frame_ready), 0);
        $display("phase reset-mid-stream done, checks=%0d", n_checks);

        // Clean frame with pseudo-random gaps, data = address.
        cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 14'd0, x);
        run_frame(16384, -1, 16'h0000);
        check("clean frame_ready", 32'(frame_ready), 1);
        check("clean s_ready",     32'(s_ready), 0);
        check("clean last addr",   32'(ram_addr), 16383);
        check("clean frame_count", 32'(frame_count), 1);
        check("clean err_framing", 32'(err_framing), 0);
        check("clean busy",        32'(busy), 0);
        $display("phase clean-frame done, checks=%0d", n_checks);

        // Hold in FULL: no acceptance, start ignored.
        for (int i = 0; i < 3; i++) cyc(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0, 14'd0, x);
        check("hold xfer", 32'(x), 0);
        cyc(1'b1, 16'hDEAD, 1'b0, 1'b1, 1'b0, 14'd0, x);
        check("start in FULL frame_ready", 32'(frame_ready), 1);
        check("start in FULL busy",        32'(busy), 0);
        bad = 0;
        for (int a = 0; a < 16384; a++) if (mem[a] !== 16'(a)) bad++;
        check("clean ram contents", 32'(bad), 0);

        // start together with release: release wins, ends in IDLE.
        cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 14'd0, x);
        check("start+release frame_ready", 32'(frame_ready), 0);
        check("start+release busy",        32'(busy), 0);
        check("start+release s_ready",     32'(s_ready), 0);
        cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 14'd0, x);
        check("release in IDLE busy",        32'(busy), 0);
        check("release in IDLE frame_ready", 32'(frame_ready), 0);
        $display("phase hold-release done, checks=%0d", n_checks);

        // Short block: s_last at channel 2 idx 999 (sample 5095).
        cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 14'd0, x);
        check("frame2 busy", 32'(busy), 1);
        run_frame(15336, 5095, 16'hA5A5);
        check("short frame_count", 32'(frame_count), 2);
        check("short err_framing", 32'(err_framing), 1);
        check("short frame_ready", 32'(frame_ready), 1);
        cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 14'd0, x);
        check("short ram 5095 written", 32'(mem[5095]), 32'(16'd5095 ^ 16'hA5A5));
        check("short ram 5096 stale",   32'(mem[5096]), 5096);
        check("short ram 6144 written", 32'(mem[6144]), 32'(16'd6144 ^ 16'hA5A5));
        cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 14'd0, x);
        check("release frame_ready", 32'(frame_ready), 0);
        check("release keeps err",   32'(err_framing), 1);
        cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 14'd0, x);
        check("start clears err",     32'(err_framing), 0);
        check("frame_count held",     32'(frame_count), 2);
        $display("phase short-block done, checks=%0d", n_checks);

        // Long block: no s_last at channel 0 idx 2047; next sample goes to 2048.
        for (int i = 0; i < 2048; i++) cyc(1'b1, 16'(i), 1'b0, 1'b0, 1'b0, 14'(i), x);
        check("long err_framing", 32'(err_framing), 1);
        cyc(1'b1, 16'h7777, 1'b0, 1'b0, 1'b0, 14'd2048, x);
        check("long next addr", 32'(ram_addr), 2048);
        $display("phase long-block done, checks=%0d", n_checks);

        check("write enable timing", 32'(we_bad), 0);
        check("write addr/data",     32'(addr_bad), 0);
        check("err_framing track",   32'(err_bad), 0);
        check("frame_ready track",   32'(fr_bad), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
